// File: rtl/gray_sched_pkg.sv
// Shared types, direction constants and code-conversion functions for the
// binary/Gray conversion scheduler.
package gray_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam logic DIR_B2G = 1'b0;
  localparam logic DIR_G2B = 1'b1;

  // Functions work on a fixed container; callers zero-extend and pass their width.
  localparam int CODE_MAX_W = 32;

  function automatic logic [CODE_MAX_W-1:0] width_mask(input int w);
    logic [CODE_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < CODE_MAX_W; i++) m[i] = (i < w);
    return m;
  endfunction

  function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] b,
                                                     input int w);
    logic [CODE_MAX_W-1:0] bb;
    bb = b & width_mask(w);
    return bb ^ (bb >> 1);
  endfunction

  function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] g,
                                                     input int w);
    logic [CODE_MAX_W-1:0] gg;
    logic [CODE_MAX_W-1:0] b;
    gg = g & width_mask(w);
    b = '0;
    b[CODE_MAX_W-1] = gg[CODE_MAX_W-1];
    for (int i = CODE_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ gg[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_sched_if.sv
// Request and response bundle between requesters, the scheduler and the
// consumer of converted codes.
interface gray_conv_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int ID_W = $clog2(N_REQ);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. A source holds valid and its payload stable until that edge;
  // ready may depend combinationally on valid.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_dir;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;

  modport master (
    output req_valid, req_data, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/gray_conv_core.sv
// Combinational binary<->Gray converter; the single shared conversion resource.
module gray_conv_core
  import gray_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    if (dir == DIR_G2B) dout = WIDTH'(gray2bin(CODE_MAX_W'(din), WIDTH));
    else                dout = WIDTH'(bin2gray(CODE_MAX_W'(din), WIDTH));
  end

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler routing N_REQ requesters through one Gray converter;
// one request in flight at a time (IDLE -> CONV -> RESP).
module gray_conv_sched
  import gray_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_conv_sched_if.slave   bus,
  output sched_state_e       dbg_state
);

  localparam int ID_W = $clog2(N_REQ);

  sched_state_e     state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic [ID_W-1:0]  cap_id;
  logic [WIDTH-1:0] cap_data;
  logic             cap_dir;
  logic [WIDTH-1:0] conv_out;
  logic [WIDTH-1:0] rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             accept;
  logic             rsp_fire;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && bus.req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  assign accept   = (state == IDLE) && grant_found;
  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  gray_conv_core #(.WIDTH(WIDTH)) u_core (
    .dir  (cap_dir),
    .din  (cap_data),
    .dout (conv_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      cap_id     <= '0;
      cap_data   <= '0;
      cap_dir    <= DIR_B2G;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      if (accept) begin
        cap_id   <= grant_id;
        cap_data <= bus.req_data[grant_id*WIDTH +: WIDTH];
        cap_dir  <= bus.req_dir[grant_id];
      end
      if (state == CONV) begin
        rsp_data_q <= conv_out;
        rsp_id_q   <= cap_id;
      end
      // Pointer moves past the served requester only once its result is taken.
      if (rsp_fire) rr_ptr <= (cap_id == ID_W'(N_REQ - 1)) ? '0 : cap_id + 1'b1;
    end
  end

  // Gated by rst_n so grants vanish the moment reset asserts.
  assign bus.req_ready = (accept && rst_n) ? (N_REQ'(1) << grant_id) : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_gray_conv_sched.sv
// Bench for gray_conv_sched: directed scenarios with a result scoreboard.
module tb_gray_conv_sched;
  import gray_sched_pkg::*;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  sched_state_e dbg_state;
  logic [IDW+W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_conv_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

  gray_conv_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference conversion: Gray->bin bit i is the XOR of all Gray bits >= i.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dir);
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    if (dir == DIR_G2B) begin
      for (int i = 0; i < W; i++) begin
        t = d >> i;
        r[i] = ^t;
      end
    end else begin
      r = d ^ (d >> 1);
    end
    return r;
  endfunction

  task automatic set_req(input int id, input logic [W-1:0] d, input logic dir);
    bus.req_valid[id] = 1'b1;
    bus.req_data[id*W +: W] = d;
    bus.req_dir[id] = dir;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic drive_req(input int id, input logic [W-1:0] d, input logic dir,
                           output bit granted);
    granted = 1'b0;
    set_req(id, d, dir);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready[id] === 1'b1) begin
        exp_q.push_back({IDW'(id), model(d, dir)});
        granted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (granted) begin
      @(posedge clk); #1;
    end
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic collect_rsp(output bit got, output logic [IDW+W-1:0] obs);
    got = 1'b0;
    obs = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.rsp_valid === 1'b1) begin
        obs = {bus.rsp_id, bus.rsp_data};
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (got) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_data = '0;
    bus.req_dir = '0;
    bus.req_valid = '1;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    vectors++; if (bus.rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== '0) begin miscompares++; $display("FAIL reset_rsp_id: got %h want 0", bus.rsp_id); end
    vectors++; if (bus.req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [IDW+W-1:0] exp_v;
    @(posedge clk); #1;
    set_req(1, 4'b1011, DIR_B2G);
    #1;
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL basic_grant: got %b want 0010", bus.req_ready); end
    exp_q.push_back({2'd1, model(4'b1011, DIR_B2G)});
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    #1;
    vectors++; if (dbg_state !== CONV) begin miscompares++; $display("FAIL basic_conv_state: got %0d want %0d", dbg_state, CONV); end
    vectors++; if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_conv_outputs: got ready=%b valid=%b want 0000/0", bus.req_ready, bus.rsp_valid); end
    @(posedge clk); #2;
    vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: got rsp_valid=%b want 1", bus.rsp_valid); end
    exp_v = 'x;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++; if ({bus.rsp_id, bus.rsp_data} !== exp_v) begin miscompares++; $display("FAIL basic_result: got %h want %h", {bus.rsp_id, bus.rsp_data}, exp_v); end
    vectors++; if ({bus.rsp_id, bus.rsp_data} !== {2'd1, 4'b1110}) begin miscompares++; $display("FAIL basic_const: got %h want %h", {bus.rsp_id, bus.rsp_data}, {2'd1, 4'b1110}); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    #1;
    vectors++; if (dbg_state !== IDLE || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_return_idle: got state=%0d valid=%b want %0d/0", dbg_state, bus.rsp_valid, IDLE); end
  endtask

  task automatic test_g2b();
    bit ok, got;
    logic [IDW+W-1:0] obs, exp_v;
    @(posedge clk); #1;
    drive_req(2, 4'b1110, DIR_G2B, ok);
    collect_rsp(got, obs);
    exp_v = 'x;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++; if (!ok || !got || obs !== exp_v) begin miscompares++; $display("FAIL g2b_result: got %h (granted=%0d seen=%0d) want %h", obs, ok, got, exp_v); end
    vectors++; if (obs !== {2'd2, 4'b1011}) begin miscompares++; $display("FAIL g2b_const: got %h want %h", obs, {2'd2, 4'b1011}); end
  endtask

  task automatic test_sweep();
    bit ok, got;
    logic [IDW+W-1:0] obs, exp_v;
    logic [W-1:0] r;
    @(posedge clk); #1;
    for (int v = 0; v < 16; v++) begin
      for (int d = 0; d < 2; d++) begin
        drive_req(v % N, W'(v), d[0], ok);
        collect_rsp(got, obs);
        exp_v = 'x;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        vectors++; if (!ok || !got || obs !== exp_v) begin miscompares++; $display("FAIL sweep_fwd v=%0d dir=%0d: got %h want %h", v, d, obs, exp_v); end
        r = obs[W-1:0];
        drive_req(v % N, r, ~d[0], ok);
        collect_rsp(got, obs);
        exp_v = 'x;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        vectors++; if (!ok || !got || obs !== exp_v) begin miscompares++; $display("FAIL sweep_back v=%0d dir=%0d: got %h want %h", v, d, obs, exp_v); end
        vectors++; if (obs[W-1:0] !== W'(v)) begin miscompares++; $display("FAIL sweep_roundtrip v=%0d dir=%0d: got %h want %h", v, d, obs[W-1:0], W'(v)); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [IDW+W-1:0] exp_v;
    logic [IDW-1:0] exp_id;
    int n_rsp, last_cyc, gid;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, W'(i * 3 + 1), i[0]);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_rsp = 0;
    last_cyc = 0;
    exp_id = '0;
    for (int k = 0; k < 40 && n_rsp < 6; k++) begin
      #1;
      if (bus.req_ready !== '0) begin
        gid = 0;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) gid = i;
        exp_q.push_back({IDW'(gid), model(bus.req_data[gid*W +: W], bus.req_dir[gid])});
      end
      if (bus.rsp_valid === 1'b1) begin
        exp_v = 'x;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        vectors++; if ({bus.rsp_id, bus.rsp_data} !== exp_v) begin miscompares++; $display("FAIL rr_result #%0d: got %h want %h", n_rsp, {bus.rsp_id, bus.rsp_data}, exp_v); end
        vectors++; if (bus.rsp_id !== exp_id) begin miscompares++; $display("FAIL rr_order #%0d: got id %0d want %0d", n_rsp, bus.rsp_id, exp_id); end
        if (n_rsp > 0) begin
          vectors++; if (cyc - last_cyc != 3) begin miscompares++; $display("FAIL rr_interval #%0d: got %0d cycles want 3", n_rsp, cyc - last_cyc); end
        end
        last_cyc = cyc;
        exp_id = exp_id + 1'b1;
        n_rsp++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    vectors++; if (n_rsp != 6 || exp_q.size() != 0) begin miscompares++; $display("FAIL rr_count: got %0d results, %0d pending want 6, 0", n_rsp, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_skip();
    bit ok, got;
    logic [IDW+W-1:0] obs, exp_v;
    logic [IDW-1:0] want_ids [3];
    int n_rsp, gid;
    want_ids[0] = 2'd3; want_ids[1] = 2'd0; want_ids[2] = 2'd3;
    @(posedge clk); #1;
    drive_req(0, 4'h6, DIR_B2G, ok);
    collect_rsp(got, obs);
    exp_v = 'x;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++; if (!ok || !got || obs !== exp_v) begin miscompares++; $display("FAIL skip_setup: got %h want %h", obs, exp_v); end
    set_req(0, 4'h5, DIR_B2G);
    set_req(3, 4'h9, DIR_G2B);
    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 30 && n_rsp < 3; k++) begin
      #1;
      if (bus.req_ready !== '0) begin
        gid = 0;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) gid = i;
        exp_q.push_back({IDW'(gid), model(bus.req_data[gid*W +: W], bus.req_dir[gid])});
      end
      if (bus.rsp_valid === 1'b1) begin
        exp_v = 'x;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        vectors++; if ({bus.rsp_id, bus.rsp_data} !== exp_v) begin miscompares++; $display("FAIL skip_result #%0d: got %h want %h", n_rsp, {bus.rsp_id, bus.rsp_data}, exp_v); end
        vectors++; if (bus.rsp_id !== want_ids[n_rsp]) begin miscompares++; $display("FAIL skip_order #%0d: got id %0d want %0d", n_rsp, bus.rsp_id, want_ids[n_rsp]); end
        n_rsp++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    vectors++; if (n_rsp != 3) begin miscompares++; $display("FAIL skip_count: got %0d results want 3", n_rsp); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok, got, seen;
    logic [IDW+W-1:0] obs, exp_v, held;
    @(posedge clk); #1;
    drive_req(2, 4'b0110, DIR_B2G, ok);
    set_req(1, 4'b1100, DIR_G2B);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    held = 'x;
    if (exp_q.size() > 0) held = exp_q.pop_front();
    vectors++; if (!ok || !seen || {bus.rsp_id, bus.rsp_data} !== held) begin miscompares++; $display("FAIL bp_first: got %h (seen=%0d) want %h", {bus.rsp_id, bus.rsp_data}, seen, held); end
    repeat (5) begin
      @(posedge clk); #2;
      vectors++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_data} !== held || bus.req_ready !== '0) begin
        miscompares++;
        $display("FAIL bp_hold: got valid=%b rsp=%h ready=%b want 1/%h/0000", bus.rsp_valid, {bus.rsp_id, bus.rsp_data}, bus.req_ready, held);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    #1;
    vectors++; if (dbg_state !== IDLE || bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_release: got state=%0d ready=%b want %0d/0010", dbg_state, bus.req_ready, IDLE); end
    exp_q.push_back({2'd1, model(4'b1100, DIR_G2B)});
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    collect_rsp(got, obs);
    exp_v = 'x;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++; if (!got || obs !== exp_v) begin miscompares++; $display("FAIL bp_next: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    bit ok, got, seen;
    logic [IDW+W-1:0] obs, exp_v;
    @(posedge clk); #1;
    drive_req(1, 4'b0011, DIR_B2G, ok);
    #1;
    set_req(0, 4'b1001, DIR_B2G);
    set_req(2, 4'b0111, DIR_B2G);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (!ok || bus.rsp_valid !== 1'b0 || bus.req_ready !== '0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL arst_conv: got valid=%b ready=%b state=%0d want 0/0000/%0d", bus.rsp_valid, bus.req_ready, dbg_state, IDLE);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL arst_conv_regrant: got %b want 0001", bus.req_ready); end
    exp_q.push_back({2'd0, model(4'b1001, DIR_B2G)});
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    exp_v = 'x;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++; if (!seen || {bus.rsp_id, bus.rsp_data} !== exp_v) begin miscompares++; $display("FAIL arst_resp_before: got %h (seen=%0d) want %h", {bus.rsp_id, bus.rsp_data}, seen, exp_v); end
    set_req(0, 4'b0101, DIR_G2B);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0 || {bus.rsp_id, bus.rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL arst_resp: got valid=%b ready=%b rsp=%h want 0/0000/00", bus.rsp_valid, bus.req_ready, {bus.rsp_id, bus.rsp_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL arst_resp_regrant: got %b want 0001", bus.req_ready); end
    exp_q.push_back({2'd0, model(4'b0101, DIR_G2B)});
    @(posedge clk); #1;
    bus.req_valid = '0;
    collect_rsp(got, obs);
    exp_v = 'x;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++; if (!got || obs !== exp_v) begin miscompares++; $display("FAIL arst_resume: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_g2b();
    test_sweep();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_conv_sched.md
# gray_conv_sched

Shared-converter scheduler for the binary/Gray code datapath. Accepts conversion requests from `N_REQ` independent requesters, arbitrates round-robin, and routes one request at a time through a single converter core. Each conversion runs binary→Gray or Gray→binary, and the result is returned with the requester ID over a valid/ready response port. Sits between requester logic and the downstream consumer of converted codes.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 4, code width in bits (≥2)
- `ID_W`, $clog2(N_REQ), width of requester ID (derived, not overridable)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero
- `req_data`  in  N_REQ*WIDTH  operand, requester i at bits [i*WIDTH +: WIDTH]
- `req_dir`  in  N_REQ  per-requester direction: 0 = bin→Gray, 1 = Gray→bin
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  WIDTH  converted code
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_data`

## Operation
- FSM states are IDLE, CONV and RESP.
- **IDLE**
  - If any `req_valid` is set, the arbiter picks the first set bit at or after the round-robin pointer `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready[g]` = 1 combinationally in the same cycle.
  - On that edge, the block captures `req_data` slice g, `req_dir[g]` and g, then moves to CONV.
  - If no `req_valid` is set, it stays in IDLE.
- **CONV**: the core converts the captured operand. `rsp_data` and `rsp_id` are registered, and the FSM moves to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_valid && rsp_ready`: `rr_ptr` ← (g+1) mod N_REQ, then go to IDLE.
  - Otherwise hold. `rsp_data` and `rsp_id` stay stable.
- `req_ready` is 0 in CONV and RESP.
- Requesters keep `req_valid` and data asserted until accepted. `req_valid` is never dropped by the block.
- Conversion rules, bitwise, with no width change:
  - bin→Gray: g[W-1] = b[W-1]; g[i] = b[i] ^ b[i+1].
  - Gray→bin: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i], an MSB-down prefix XOR.
- A requester whose `req_valid` is held high is served within N_REQ grants.
- Reset values: FSM = IDLE, `rr_ptr` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `req_ready` = 0.

## Timing
- Request accepted at edge T, which ends the IDLE cycle. CONV is the cycle after T. `rsp_valid` rises after edge T+1.
- Minimum latency is 2 cycles from acceptance to `rsp_valid`.
- With `rsp_ready` tied high, peak throughput is 1 result per 3 cycles.
- The arbitration decision uses `rr_ptr` as registered. A new `req_valid` arriving in CONV or RESP is not seen until IDLE.
- `rsp_ready` asserted in the first RESP cycle: handshake completes that edge, and the next IDLE cycle can accept again.
- If `rst_n` is asserted in any state, all outputs drop to reset values immediately and asynchronously. Any in-flight result is discarded with no partial response. Operation resumes in IDLE on the first edge after deassertion.
- If the pointer points at a requester that is not valid, the search skips ahead. The pointer advances only on response handshake, never on acceptance.

## Structure
- Package `gray_sched_pkg` holds:
  - state enum `sched_state_e` {IDLE, CONV, RESP}
  - direction constants `DIR_B2G` = 1'b0 and `DIR_G2B` = 1'b1
  - functions `bin2gray` and `gray2bin`, parameterised on width
- Sub-module `gray_conv_core`:
  - Purely combinational, parameter WIDTH.
  - Ports: `dir`, `din`, `dout`; wraps the two package functions.
  - Instantiated once. This is the shared resource.
- The round-robin find-first-from-pointer logic stays in the top module.

## Test plan
- Reset, then requester 1 sends `req_data` 4'b1011 with dir 0 → `req_ready[1]` high for one cycle. Two cycles later `rsp_valid` = 1, `rsp_data` = 4'b1110, `rsp_id` = 1.
- Requester 2 sends 4'b1110 with dir 1 → `rsp_data` = 4'b1011, `rsp_id` = 2. Sweep all 16 values in both directions; each round-trip returns the original value.
- All 4 `req_valid` held high from reset, `rsp_ready` = 1 → `rsp_id` sequence is 0,1,2,3,0,1, with one result every 3 cycles.
- Only requesters 0 and 3 valid, pointer at 1 → grant 3 first, then 0, then 3.
- `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stay constant and `req_ready` stays 0. Release → handshake, IDLE next cycle.
- `rst_n` pulsed low mid-CONV and again mid-RESP → `rsp_valid` = 0 and `req_ready` = 0 immediately. After release, a pending `req_valid[0]` is granted first.
